// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: one grant per cycle into a registered write stage
// that also serves as a decode forwarding source. `REGWR_FIXED_PRIO_EN selects fixed priority.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_rf_we,
    output logic [ADDR_W-1:0]         o_rf_waddr,
    output logic [DATA_W-1:0]         o_rf_wdata,
    input  logic [ADDR_W-1:0]         i_fwd_addr,
    output logic                      o_fwd_hit,
    output logic [DATA_W-1:0]         o_fwd_data
);

    logic [NUM_REQ-1:0] w_grant_p0;
    logic               w_found_p0;
    logic [ADDR_W-1:0]  w_gaddr_p0;
    logic [DATA_W-1:0]  w_gdata_p0;

    logic               r_we_p1;
    logic [ADDR_W-1:0]  r_waddr_p1;
    logic [DATA_W-1:0]  r_wdata_p1;

`ifdef REGWR_FIXED_PRIO_EN
    // p0: lowest valid index wins
    always_comb begin
        w_grant_p0 = '0;
        w_found_p0 = 1'b0;
        w_gaddr_p0 = '0;
        w_gdata_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found_p0 && i_req_valid[i]) begin
                w_found_p0    = 1'b1;
                w_grant_p0[i] = 1'b1;
                w_gaddr_p0    = i_req_addr[i*ADDR_W +: ADDR_W];
                w_gdata_p0    = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // p1: registered write stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we_p1    <= 1'b0;
            r_waddr_p1 <= '0;
            r_wdata_p1 <= '0;
        end else begin
            r_we_p1 <= 1'b0;
            if (w_found_p0) begin
                r_we_p1    <= (w_gaddr_p0 != '0);
                r_waddr_p1 <= w_gaddr_p0;
                r_wdata_p1 <= w_gdata_p0;
            end
        end
    end
`else
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_gidx_p0;

    // p0: scan starting one past the last granted requester
    always_comb begin
        w_grant_p0 = '0;
        w_found_p0 = 1'b0;
        w_gidx_p0  = '0;
        w_gaddr_p0 = '0;
        w_gdata_p0 = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found_p0 && i_req_valid[idx]) begin
                w_found_p0      = 1'b1;
                w_grant_p0[idx] = 1'b1;
                w_gidx_p0       = PTR_W'(idx);
                w_gaddr_p0      = i_req_addr[idx*ADDR_W +: ADDR_W];
                w_gdata_p0      = i_req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    // p1: registered write stage; $zero writes are acknowledged but not enabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we_p1    <= 1'b0;
            r_waddr_p1 <= '0;
            r_wdata_p1 <= '0;
            r_rr_ptr   <= PTR_W'(NUM_REQ - 1);
        end else begin
            r_we_p1 <= 1'b0;
            if (w_found_p0) begin
                r_we_p1    <= (w_gaddr_p0 != '0);
                r_waddr_p1 <= w_gaddr_p0;
                r_wdata_p1 <= w_gdata_p0;
                r_rr_ptr   <= w_gidx_p0;
            end
        end
    end
`endif

    assign o_req_ready = w_grant_p0 & {NUM_REQ{i_rst_n}};
    assign o_rf_we     = r_we_p1;
    assign o_rf_waddr  = r_waddr_p1;
    assign o_rf_wdata  = r_wdata_p1;
    // covers the cycle where a register-file read still returns the old value
    assign o_fwd_hit   = r_we_p1 && (r_waddr_p1 == i_fwd_addr) && (i_fwd_addr != '0);
    assign o_fwd_data  = r_wdata_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [ADDR_W-1:0]         a0, a1, a2;
    logic [DATA_W-1:0]         d0, d1, d2;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;
    logic [ADDR_W-1:0]         fwd_addr;
    logic                      fwd_hit;
    logic [DATA_W-1:0]         fwd_data;

    int n_vec = 0;
    int n_err = 0;

    regfile_write_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid),
        .i_req_addr ({a2, a1, a0}),
        .i_req_data ({d2, d1, d0}),
        .o_req_ready(req_ready),
        .o_rf_we    (rf_we),
        .o_rf_waddr (rf_waddr),
        .o_rf_wdata (rf_wdata),
        .i_fwd_addr (fwd_addr),
        .o_fwd_hit  (fwd_hit),
        .o_fwd_data (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [NUM_REQ-1:0] exp_g [6];
    logic [ADDR_W-1:0]  exp_a [6];

    initial begin
        rst_n = 1'b0; req_valid = '0; fwd_addr = '0;
        a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;

        // 1. reset state, ready gated even with valid requests
        #3;
        check("rst_we",    64'(rf_we),    64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_fwd",   64'(fwd_hit),  64'd0);
        req_valid = 3'b111;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_we", 64'(rf_we), 64'd0);
        end

        // 2. single write
        req_valid = 3'b001; a0 = 5'd5; d0 = 32'hDEADBEEF;
        #1;
        check("single_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        check("single_we",    64'(rf_we),    64'd1);
        check("single_waddr", 64'(rf_waddr), 64'd5);
        check("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        #1;
        check("single_ready_drop", 64'(req_ready), 64'd0);
        tick();
        check("nogrant_we",    64'(rf_we),    64'd0);
        check("nogrant_waddr", 64'(rf_waddr), 64'd5);

        // 3. all requesters valid for six cycles from a fresh reset
        pulse_reset();
        a0 = 5'd1; a1 = 5'd2; a2 = 5'd3;
        d0 = 32'h100; d1 = 32'h200; d2 = 32'h300;
`ifdef REGWR_FIXED_PRIO_EN
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        exp_a = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
`else
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_a = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
`endif
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr_ready%0d", i), 64'(req_ready), 64'(exp_g[i]));
            tick();
            check($sformatf("rr_waddr%0d", i), 64'(rf_waddr), 64'(exp_a[i]));
            check($sformatf("rr_we%0d", i),    64'(rf_we),    64'd1);
        end

        // 4. write to $zero is acknowledged but not enabled
        req_valid = 3'b010; a1 = 5'd0; d1 = 32'h1234;
        #1;
        check("zero_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b111;
        check("zero_we",    64'(rf_we),    64'd0);
        check("zero_wdata", 64'(rf_wdata), 64'h1234);
        check("zero_fwd",   64'(fwd_hit),  64'd0);
        #1;
`ifdef REGWR_FIXED_PRIO_EN
        check("zero_next_ready", 64'(req_ready), 64'b001);
        tick();
        check("zero_next_waddr", 64'(rf_waddr), 64'd1);
`else
        check("zero_next_ready", 64'(req_ready), 64'b100);
        tick();
        check("zero_next_waddr", 64'(rf_waddr), 64'd3);
`endif
        req_valid = '0;
        check("zero_next_we", 64'(rf_we), 64'd1);

        // 5. forwarding from the write stage
        req_valid = 3'b001; a0 = 5'd7; d0 = 32'h55;
        #1;
        check("fwd_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        fwd_addr = 5'd7;
        #1;
        check("fwd_hit7",  64'(fwd_hit),  64'd1);
        check("fwd_data7", 64'(fwd_data), 64'h55);
        fwd_addr = 5'd8;
        #1;
        check("fwd_hit8", 64'(fwd_hit), 64'd0);
        fwd_addr = 5'd0;
        #1;
        check("fwd_hit0", 64'(fwd_hit), 64'd0);
        fwd_addr = 5'd7;
        tick();
        check("fwd_stale", 64'(fwd_hit), 64'd0);

        // 6. reset in the middle of a staged write
        req_valid = 3'b010; a1 = 5'd9; d1 = 32'h99;
        #1;
        check("midrst_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        check("midrst_we_pre", 64'(rf_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_we",    64'(rf_we),    64'd0);
        check("midrst_waddr", 64'(rf_waddr), 64'd0);
        #1;
        rst_n = 1'b1;
        req_valid = 3'b011;
        #1;
        check("midrst_prio", 64'(req_ready), 64'b001);
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
